// File: rtl/act_requant_unit.sv
// Requantise a layer's accumulator vector: fixed-point scale, round, saturate to int8 and apply an activation.
// Latency: beat b lands in layer_out B+... two edges after its issue; done pulses B+2 cycles after an accepted start.
// Backpressure: none; start is accepted only in IDLE and inputs must stay stable while busy.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   start, mode, scale       pass request; mode/scale are captured when start is accepted
//   inputs                   NUM_CH packed signed accumulators, channel c at [c*IN_WIDTH +: IN_WIDTH]
//   layer_out                NUM_CH packed signed activations, channel c at [c*OUT_WIDTH +: OUT_WIDTH]
//   busy, done, sat_count    pass in flight, one-cycle completion pulse, number of saturated elements
module act_requant_unit #(
  parameter int NUM_CH      = 512,
  parameter int LANES       = 8,
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 8,
  parameter int SCALE_WIDTH = 16,
  parameter int SCALE_FRAC  = 16,
  parameter int TANH_LIM    = 127
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [1:0]                    mode,
  input  logic [SCALE_WIDTH-1:0]        scale,
  input  logic [NUM_CH*IN_WIDTH-1:0]    inputs,
  output logic [NUM_CH*OUT_WIDTH-1:0]   layer_out,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(NUM_CH+1)-1:0]   sat_count
);

  localparam int B  = NUM_CH / LANES;
  localparam int BW = (B > 1) ? $clog2(B) : 1;
  localparam int PW = IN_WIDTH + SCALE_WIDTH + 1;  // exact product width
  localparam int RW = PW + 1;                      // headroom for the rounding offset
  localparam int CW = $clog2(NUM_CH + 1);

  localparam logic signed [RW-1:0]        HALF = RW'(1) << (SCALE_FRAC - 1);
  localparam logic signed [RW-1:0]        QMAX = RW'((longint'(1) << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0]        QMIN = ~QMAX;  // two's complement: -(QMAX+1)
  localparam logic signed [OUT_WIDTH-1:0] TL   = OUT_WIDTH'(TANH_LIM);
  localparam logic signed [OUT_WIDTH-1:0] NTL  = OUT_WIDTH'(-TANH_LIM);

  if (NUM_CH % LANES != 0) begin : g_bad_cfg
    $error("act_requant_unit: NUM_CH must be a multiple of LANES");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                  state;
  logic [BW-1:0]           beat;
  logic [1:0]              mode_q;
  logic [SCALE_WIDTH-1:0]  scale_q;

  logic                    s1_vld;
  logic [BW-1:0]           s1_beat;
  logic signed [PW-1:0]    s1_prod [LANES];

  // Stage 1: exact signed product of each lane with the zero-extended scale.
  logic signed [IN_WIDTH-1:0] lane_in [LANES];
  logic signed [PW-1:0]       prod_c  [LANES];
  logic signed [PW-1:0]       scale_ext;

  always_comb begin
    scale_ext = PW'($signed({1'b0, scale_q}));
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = $signed(inputs[(int'(beat) * LANES + l) * IN_WIDTH +: IN_WIDTH]);
      prod_c[l]  = PW'(lane_in[l]) * scale_ext;
    end
  end

  // Stage 2: round half toward +inf, saturate, then activation on the saturated value.
  logic signed [RW-1:0]        sum_c [LANES];
  logic signed [RW-1:0]        rnd_c [LANES];
  logic signed [OUT_WIDTH-1:0] q_c   [LANES];
  logic signed [OUT_WIDTH-1:0] act_c [LANES];
  logic [LANES-1:0]            clip_c;
  logic [CW-1:0]               clip_num;

  always_comb begin
    clip_c   = '0;
    clip_num = '0;
    for (int l = 0; l < LANES; l++) begin
      sum_c[l] = RW'(s1_prod[l]) + HALF;
      rnd_c[l] = sum_c[l] >>> SCALE_FRAC;
      if (rnd_c[l] > QMAX) begin
        q_c[l]    = QMAX[OUT_WIDTH-1:0];
        clip_c[l] = 1'b1;
      end else if (rnd_c[l] < QMIN) begin
        q_c[l]    = QMIN[OUT_WIDTH-1:0];
        clip_c[l] = 1'b1;
      end else begin
        q_c[l]    = rnd_c[l][OUT_WIDTH-1:0];
      end
      case (mode_q)
        2'd1:    act_c[l] = (q_c[l] < 0) ? '0 : q_c[l];
        2'd2:    act_c[l] = (q_c[l] > TL) ? TL : ((q_c[l] < NTL) ? NTL : q_c[l]);
        default: act_c[l] = q_c[l];  // identity, and the reserved encoding
      endcase
      clip_num = clip_num + CW'(clip_c[l]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      beat      <= '0;
      mode_q    <= '0;
      scale_q   <= '0;
      s1_vld    <= 1'b0;
      s1_beat   <= '0;
      layer_out <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sat_count <= '0;
    end else begin
      done   <= 1'b0;
      s1_vld <= 1'b0;

      if (s1_vld) begin
        for (int l = 0; l < LANES; l++)
          layer_out[(int'(s1_beat) * LANES + l) * OUT_WIDTH +: OUT_WIDTH] <= act_c[l];
        sat_count <= sat_count + clip_num;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q    <= mode;
            scale_q   <= scale;
            busy      <= 1'b1;
            sat_count <= '0;
            beat      <= '0;
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          s1_vld  <= 1'b1;
          s1_beat <= beat;
          s1_prod <= prod_c;
          beat    <= beat + BW'(1);
          if (beat == BW'(B - 1)) state <= S_DRAIN;
        end
        // The last beat sits in stage 1 here and is written to layer_out on this edge.
        S_DRAIN: state <= S_DONE;
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_act_requant_unit.sv
module tb_act_requant_unit;

  localparam int NUM_CH      = 16;
  localparam int LANES       = 4;
  localparam int IN_WIDTH    = 32;
  localparam int OUT_WIDTH   = 8;
  localparam int SCALE_WIDTH = 16;
  localparam int SCALE_FRAC  = 8;
  localparam int TANH_LIM    = 64;
  localparam int B           = NUM_CH / LANES;
  localparam int CW          = $clog2(NUM_CH + 1);

  logic                         clk;
  logic                         rst;
  logic                         start;
  logic [1:0]                   mode;
  logic [SCALE_WIDTH-1:0]       scale;
  logic [NUM_CH*IN_WIDTH-1:0]   inputs;
  logic [NUM_CH*OUT_WIDTH-1:0]  layer_out;
  logic                         busy;
  logic                         done;
  logic [CW-1:0]                sat_count;

  act_requant_unit #(
    .NUM_CH(NUM_CH), .LANES(LANES), .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH), .SCALE_FRAC(SCALE_FRAC), .TANH_LIM(TANH_LIM)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .scale(scale), .inputs(inputs),
    .layer_out(layer_out), .busy(busy), .done(done), .sat_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     checks   = 0;
  int     failures = 0;
  int     done_seen = 0;
  longint cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NUM_CH*OUT_WIDTH-1:0] lo;
    int                          sat;
    longint                      due;
  } exp_t;

  exp_t sb[$];
  int   cur_in [NUM_CH];

  task automatic chk_int(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_vec(input string name, input logic [NUM_CH*OUT_WIDTH-1:0] act,
                         input logic [NUM_CH*OUT_WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic straight from the requantisation rules.
  function automatic void model(input int m, input int s, input int x[NUM_CH],
                                output logic [NUM_CH*OUT_WIDTH-1:0] lo, output int sat);
    longint qmax = (longint'(1) << (OUT_WIDTH - 1)) - 1;
    longint qmin = -qmax - 1;
    sat = 0;
    lo  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      longint r, q;
      r = (longint'(x[c]) * longint'(s) + (longint'(1) << (SCALE_FRAC - 1))) >>> SCALE_FRAC;
      q = r;
      if (r > qmax) begin q = qmax; sat++; end
      else if (r < qmin) begin q = qmin; sat++; end
      if (m == 1 && q < 0) q = 0;
      if (m == 2) begin
        if (q > TANH_LIM) q = TANH_LIM;
        if (q < -TANH_LIM) q = -TANH_LIM;
      end
      lo[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(q);
    end
  endfunction

  // Monitor: every done pulse is matched against the oldest outstanding pass.
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      done_seen++;
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk_vec("layer_out", layer_out, e.lo);
        chk_int("sat_count", longint'(sat_count), longint'(e.sat));
        chk_int("done_cycle", cyc, e.due);
        chk_int("busy_in_done_cycle", longint'(busy), 0);
      end
    end
  end

  task automatic load_inputs();
    for (int c = 0; c < NUM_CH; c++) inputs[c*IN_WIDTH +: IN_WIDTH] = cur_in[c];
  endtask

  // Called half a cycle away from the rising edge; start is sampled by the next edge.
  task automatic issue(input int m, input int s);
    exp_t e;
    load_inputs();
    mode  = 2'(m);
    scale = SCALE_WIDTH'(s);
    start = 1'b1;
    model(m, s, cur_in, e.lo, e.sat);
    e.due = cyc + 1 + B + 2;
    sb.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n0 = done_seen;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); #1;
      if (done_seen != n0) return;
    end
    checks++;
    failures++;
    $display("FAIL done_timeout_%s: got no done expected one within 30 cycles", tag);
  endtask

  task automatic set_in(input int v0, input int v1, input int v2, input int v3, input int v4);
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = 0;
    cur_in[0] = v0; cur_in[1] = v1; cur_in[2] = v2; cur_in[3] = v3; cur_in[4] = v4;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; mode = '0; scale = '0; inputs = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_int("reset_busy", longint'(busy), 0);
    chk_int("reset_done", longint'(done), 0);
    chk_int("reset_sat", longint'(sat_count), 0);
    chk_vec("reset_layer_out", layer_out, '0);
    rst = 1'b0;
    @(negedge clk); #1;

    // 1: identity at scale 0.5, with busy tracked through the whole pass
    set_in(10, -3, 3, 0, 0);
    issue(0, 128);
    chk_int("t1_busy_c1", longint'(busy), 1);
    for (int i = 2; i <= 6; i++) begin
      @(negedge clk); #1;
      if (i < 6) begin
        chk_int("t1_busy", longint'(busy), 1);
        chk_int("t1_no_early_done", longint'(done), 0);
      end
    end
    if (done_seen == 0) wait_done("t1");
    chk_int("t1_ch0", longint'($signed(layer_out[7:0])), 5);
    chk_int("t1_ch1", longint'($signed(layer_out[15:8])), -1);
    chk_int("t1_ch2", longint'($signed(layer_out[23:16])), 2);

    // 2: ReLU
    set_in(-100, 100, -1, 1, 0);
    issue(1, 128);
    wait_done("t2");
    chk_int("t2_ch1", longint'($signed(layer_out[15:8])), 50);
    chk_int("t2_ch3", longint'($signed(layer_out[31:24])), 1);

    // 3: saturation at unity scale
    set_in(1000, -1000, 127, -128, 0);
    issue(0, 256);
    wait_done("t3");
    chk_int("t3_ch0", longint'($signed(layer_out[7:0])), 127);
    chk_int("t3_ch1", longint'($signed(layer_out[15:8])), -128);
    chk_int("t3_sat", longint'(sat_count), 2);

    // 4: hard-tanh
    set_in(200, -200, 64, -65, 30);
    issue(2, 256);
    wait_done("t4");
    chk_int("t4_ch3", longint'($signed(layer_out[31:24])), -64);

    // 5a: second start plus mode/scale churn mid-pass must not disturb it
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = int'($urandom_range(0, 2000)) - 1000;
    issue(0, 200);
    start = 1'b1; mode = 2'd2; scale = 16'd7;
    @(negedge clk); #1;
    start = 1'b0; mode = 2'd1; scale = 16'd999;
    wait_done("t5a");
    repeat (10) @(negedge clk);
    #1;

    // 5b: start raised in the done cycle launches the next pass back to back
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = int'($urandom_range(0, 600)) - 300;
    issue(1, 300);
    wait_done("t5b_first");
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = int'($urandom_range(0, 600)) - 300;
    issue(2, 90);
    wait_done("t5b_second");

    // 6: reset in the middle of a pass
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = int'($urandom_range(0, 2000)) - 1000;
    issue(0, 256);
    @(negedge clk); #1;
    sb.delete();
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    chk_int("t6_busy", longint'(busy), 0);
    chk_int("t6_done", longint'(done), 0);
    chk_int("t6_sat", longint'(sat_count), 0);
    chk_vec("t6_layer_out", layer_out, '0);
    repeat (12) @(negedge clk);
    #1;
    for (int c = 0; c < NUM_CH; c++) cur_in[c] = int'($urandom_range(0, 400)) - 200;
    issue(2, 256);
    wait_done("t6_fresh");

    // Random passes, most chained straight off the previous done cycle
    for (int p = 0; p < 30; p++) begin
      int m, s;
      m = int'($urandom_range(0, 3));
      s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 600));
      for (int c = 0; c < NUM_CH; c++)
        cur_in[c] = ($urandom_range(0, 3) == 0) ? int'($urandom()) : int'($urandom_range(0, 2000)) - 1000;
      issue(m, s);
      wait_done("rand");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(negedge clk);
        #1;
      end
    end

    repeat (10) @(negedge clk);
    chk_int("sb_drained", longint'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
